// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the MEM-stage data-memory port.
// Little-endian byte-addressable word array with a fixed access latency.
// Loads are sign/zero extended here, and stores are byte-lane masked here.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are trapped
// (the store is dropped, the load returns 0, and MISALIGN is flagged).
// When the macro is undefined, low address bits are forced to alignment.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ_EN,
    input  logic        MEM_WRITE_EN,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        MEM_BUSYWAIT,
    output logic        MISALIGN
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW+1:0] a_addr;
    logic [31:0]   a_wdata;
    logic [2:0]    a_f3;
    logic          a_rd;
    logic          a_wr;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    off;
    logic [1:0]    eoff;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   new_word;

    // Upper address bits are ignored so accesses wrap around the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:AW+2];

    // The stall rises in the request cycle itself, before the request is latched.
    assign MEM_BUSYWAIT = (state == IDLE) ? (MEM_READ_EN | MEM_WRITE_EN)
                                          : (state == ACCESS);

    assign off  = a_addr[1:0];
    assign word = mem[a_addr[AW+1:2]];

`ifdef MISALIGN_TRAP_EN
    logic mis;
    assign mis      = ((a_f3[1:0] == 2'b01) && off[0]) ||
                      ((a_f3[1:0] == 2'b10) && (off != 2'b00));
    assign eoff     = off;
    assign MISALIGN = (state == DONE) && mis;
`else
    assign eoff     = (a_f3[1:0] == 2'b01) ? {off[1], 1'b0} :
                      (a_f3[1:0] == 2'b10) ? 2'b00 : off;
    assign MISALIGN = 1'b0;
`endif

    // Select the load lane and apply the extension.
    always_comb begin
        shifted  = word >> {eoff, 3'b000};
        load_val = 32'h0;
        case (a_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = shifted;
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            default: load_val = 32'h0;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (mis) load_val = 32'h0;
`endif
    end

    // Build the byte enables and the replicated store data, then merge them into the old word.
    always_comb begin
        be = 4'b0000;
        wd = a_wdata;
        case (a_f3)
            3'b000: begin be = 4'b0001 << eoff; wd = {4{a_wdata[7:0]}};  end
            3'b001: begin be = 4'b0011 << eoff; wd = {2{a_wdata[15:0]}}; end
            3'b010: begin be = 4'b1111;         wd = a_wdata;            end
            default: be = 4'b0000;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (mis) be = 4'b0000;
`endif
        for (int b = 0; b < 4; b++)
            new_word[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : word[b*8 +: 8];
    end

    // Access FSM: latch the request, count down the latency, and complete in DONE.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            READ_DATA <= 32'h0;
            a_addr    <= '0;
            a_wdata   <= 32'h0;
            a_f3      <= 3'b000;
            a_rd      <= 1'b0;
            a_wr      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (MEM_READ_EN || MEM_WRITE_EN) begin
                    a_addr  <= ADDRESS[AW+1:0];
                    a_wdata <= WRITE_DATA;
                    a_f3    <= FUNC3;
                    a_rd    <= MEM_READ_EN;
                    a_wr    <= MEM_WRITE_EN;
                    cnt     <= 4'(LATENCY - 1);
                    state   <= (LATENCY == 1) ? DONE : ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: begin
                    if (a_rd && !a_wr) READ_DATA <= load_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit the store when the DONE edge is taken; the array itself is never reset.
    always_ff @(posedge CLK) begin
        if (RESET && (state == DONE) && a_wr && (be != 4'b0000))
            mem[a_addr[AW+1:2]] <= new_word;
    end
endmodule
